// File: rtl/mmio64_to_axil32.sv
// Bridges a 64-bit AXI-lite MMIO slave port onto a 32-bit AXI4-lite register bus.
// 64-bit accesses are split into two 32-bit accesses (low word first), and their responses are merged.
module mmio64_to_axil32 #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned ID_WIDTH   = 9,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awsize,
  input  logic [USER_WIDTH-1:0] s_axi_awuser,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic [USER_WIDTH-1:0] s_axi_buser,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arsize,
  input  logic [USER_WIDTH-1:0] s_axi_aruser,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [63:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic [USER_WIDTH-1:0] s_axi_ruser,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

  state_e                wstate_q, wstate_d, rstate_q, rstate_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  ar_done_q, ar_done_d;
  logic                  wr_cap, rd_cap;
  logic [ID_WIDTH-1:0]   wid_q, rid_q;
  logic [USER_WIDTH-1:0] wuser_q, ruser_q;
  logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
  logic [63:0]           wdata_q, rdata_q, rdata_d;
  logic [7:0]            wstrb_q;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic                  rwide_q;
  logic                  unused_bits;

  assign unused_bits = ^{s_axi_awsize, s_axi_awaddr[2:0], s_axi_araddr[1:0]};

  // Write FSM: an empty strobe byte-half skips its downstream access entirely.
  always_comb begin
    wstate_d      = wstate_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    bresp_d       = bresp_q;
    wr_cap        = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    case (wstate_q)
      StIdle: begin
        if (!reset && s_axi_awvalid && s_axi_wvalid) begin
          s_axi_awready = 1'b1;
          s_axi_wready  = 1'b1;
          wr_cap        = 1'b1;
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          bresp_d       = 2'b00;
          if (s_axi_wstrb[3:0] != 4'h0) wstate_d = StLo;
          else if (s_axi_wstrb[7:4] != 4'h0) wstate_d = StHi;
          else wstate_d = StResp;
        end
      end
      StLo, StHi: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        m_axi_bready  = aw_done_q && w_done_q;
        if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wvalid && m_axi_wready) w_done_d = 1'b1;
        if (m_axi_bready && m_axi_bvalid) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (m_axi_bresp > bresp_q) bresp_d = m_axi_bresp;
          wstate_d = (wstate_q == StLo && wstrb_q[7:4] != 4'h0) ? StHi : StResp;
        end
      end
      StResp: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wstate_d = StIdle;
      end
      default: wstate_d = StIdle;
    endcase
  end

  // Read FSM: a narrow read returns its word replicated on both lanes.
  always_comb begin
    rstate_d      = rstate_q;
    ar_done_d     = ar_done_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    rd_cap        = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (rstate_q)
      StIdle: begin
        s_axi_arready = !reset;
        if (!reset && s_axi_arvalid) begin
          rd_cap    = 1'b1;
          ar_done_d = 1'b0;
          rresp_d   = 2'b00;
          rstate_d  = StLo;
        end
      end
      StLo, StHi: begin
        m_axi_arvalid = !ar_done_q;
        m_axi_rready  = ar_done_q;
        if (m_axi_arvalid && m_axi_arready) ar_done_d = 1'b1;
        if (m_axi_rready && m_axi_rvalid) begin
          ar_done_d = 1'b0;
          if (m_axi_rresp > rresp_q) rresp_d = m_axi_rresp;
          if (rstate_q == StHi) begin
            rdata_d  = {m_axi_rdata, rdata_q[31:0]};
            rstate_d = StResp;
          end else if (rwide_q) begin
            rdata_d  = {rdata_q[63:32], m_axi_rdata};
            rstate_d = StHi;
          end else begin
            rdata_d  = {m_axi_rdata, m_axi_rdata};
            rstate_d = StResp;
          end
        end
      end
      StResp: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) rstate_d = StIdle;
      end
      default: rstate_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q  <= StIdle;
      rstate_q  <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
    end
  end

  // Payload registers are only observed after a capture, so they need no reset.
  always_ff @(posedge clk) begin
    bresp_q <= bresp_d;
    rresp_q <= rresp_d;
    rdata_q <= rdata_d;
    if (wr_cap) begin
      wid_q   <= s_axi_awid;
      wuser_q <= s_axi_awuser;
      waddr_q <= {s_axi_awaddr[ADDR_WIDTH-1:3], 3'b000};
      wdata_q <= s_axi_wdata;
      wstrb_q <= s_axi_wstrb;
    end
    if (rd_cap) begin
      rid_q   <= s_axi_arid;
      ruser_q <= s_axi_aruser;
      rwide_q <= (s_axi_arsize == 3'd3);
      raddr_q <= (s_axi_arsize == 3'd3) ? {s_axi_araddr[ADDR_WIDTH-1:3], 3'b000}
                                        : {s_axi_araddr[ADDR_WIDTH-1:2], 2'b00};
    end
  end

  assign m_axi_awaddr = {waddr_q[ADDR_WIDTH-1:3], (wstate_q == StHi), 2'b00};
  assign m_axi_wdata  = (wstate_q == StHi) ? wdata_q[63:32] : wdata_q[31:0];
  assign m_axi_wstrb  = (wstate_q == StHi) ? wstrb_q[7:4] : wstrb_q[3:0];
  assign m_axi_araddr = (rstate_q == StHi) ? {raddr_q[ADDR_WIDTH-1:3], 3'b100} : raddr_q;
  assign s_axi_bid    = wid_q;
  assign s_axi_buser  = wuser_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rid    = rid_q;
  assign s_axi_ruser  = ruser_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_mmio64_to_axil32.sv
// Directed bench for mmio64_to_axil32: a behavioural 32-bit register slave plus per-scenario tasks.
module tb_mmio64_to_axil32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        s_awvalid, s_awready, s_awuser, s_wvalid, s_wready;
  logic [8:0]  s_awid;
  logic [17:0] s_awaddr;
  logic [2:0]  s_awsize;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_bvalid, s_bready, s_buser;
  logic [8:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready, s_aruser;
  logic [8:0]  s_arid;
  logic [17:0] s_araddr;
  logic [2:0]  s_arsize;
  logic        s_rvalid, s_rready, s_ruser;
  logic [8:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [17:0] m_awaddr, m_araddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  int checks = 0;
  int errors = 0;
  logic stall_en = 1'b0;
  logic hold_b = 1'b0;

  logic [31:0] rd_mem  [int];
  logic [1:0]  rd_resp [int];
  logic [1:0]  wr_resp [int];
  logic [17:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  logic [3:0]  wlog_strb[$];
  logic [17:0] rlog[$];

  logic        aw_have, w_have;
  logic [17:0] aw_addr_l;
  logic [31:0] w_data_l;
  logic [3:0]  w_strb_l;

  mmio64_to_axil32 dut (
    .clk(clk), .reset(reset),
    .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready), .s_axi_awid(s_awid),
    .s_axi_awaddr(s_awaddr), .s_axi_awsize(s_awsize), .s_axi_awuser(s_awuser),
    .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready), .s_axi_wdata(s_wdata),
    .s_axi_wstrb(s_wstrb),
    .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready), .s_axi_bid(s_bid),
    .s_axi_bresp(s_bresp), .s_axi_buser(s_buser),
    .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready), .s_axi_arid(s_arid),
    .s_axi_araddr(s_araddr), .s_axi_arsize(s_arsize), .s_axi_aruser(s_aruser),
    .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready), .s_axi_rid(s_rid),
    .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_ruser(s_ruser),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready), .m_axi_awaddr(m_awaddr),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_wdata(m_wdata),
    .m_axi_wstrb(m_wstrb),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_bresp(m_bresp),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_araddr(m_araddr),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .m_axi_rdata(m_rdata),
    .m_axi_rresp(m_rresp)
  );

  // Downstream slave: B once both AW and W landed, R the cycle after the AR handshake.
  always @(posedge clk) begin
    if (reset) begin
      m_bvalid <= 1'b0;
      m_rvalid <= 1'b0;
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
      m_bresp  <= 2'b00;
      m_rresp  <= 2'b00;
      m_rdata  <= 32'h0;
    end else begin
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_awvalid && m_awready) begin
        aw_have   <= 1'b1;
        aw_addr_l <= m_awaddr;
      end
      if (m_wvalid && m_wready) begin
        w_have   <= 1'b1;
        w_data_l <= m_wdata;
        w_strb_l <= m_wstrb;
      end
      if (aw_have && w_have && !m_bvalid && !(hold_b && aw_addr_l[2])) begin
        m_bvalid <= 1'b1;
        m_bresp  <= wr_resp.exists(int'(aw_addr_l)) ? wr_resp[int'(aw_addr_l)] : 2'b00;
        wlog_addr.push_back(aw_addr_l);
        wlog_data.push_back(w_data_l);
        wlog_strb.push_back(w_strb_l);
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= rd_mem.exists(int'(m_araddr)) ? rd_mem[int'(m_araddr)] : 32'h0;
        m_rresp  <= rd_resp.exists(int'(m_araddr)) ? rd_resp[int'(m_araddr)] : 2'b00;
        rlog.push_back(m_araddr);
      end
    end
  end

  always @(posedge clk) begin
    if (reset || !stall_en) begin
      m_awready <= 1'b1;
      m_wready  <= 1'b1;
      m_arready <= 1'b1;
    end else begin
      m_awready <= 1'($urandom_range(0, 1));
      m_wready  <= 1'($urandom_range(0, 1));
      m_arready <= 1'($urandom_range(0, 1));
    end
  end

  // Downstream request channels must hold while valid && !ready.
  logic        aw_p = 1'b0, w_p = 1'b0, ar_p = 1'b0;
  logic [17:0] aw_a, ar_a;
  logic [35:0] w_v;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (aw_p) begin
          checks++;
          if (!(m_awvalid === 1'b1 && m_awaddr === aw_a)) begin
            errors++;
            $display("FAIL m_aw_stable: valid=%b addr=%h, required valid=1 addr=%h",
                     m_awvalid, m_awaddr, aw_a);
          end
        end
        if (w_p) begin
          checks++;
          if (!(m_wvalid === 1'b1 && {m_wdata, m_wstrb} === w_v)) begin
            errors++;
            $display("FAIL m_w_stable: valid=%b w=%h, required valid=1 w=%h",
                     m_wvalid, {m_wdata, m_wstrb}, w_v);
          end
        end
        if (ar_p) begin
          checks++;
          if (!(m_arvalid === 1'b1 && m_araddr === ar_a)) begin
            errors++;
            $display("FAIL m_ar_stable: valid=%b addr=%h, required valid=1 addr=%h",
                     m_arvalid, m_araddr, ar_a);
          end
        end
      end
      aw_p = !reset && m_awvalid && !m_awready;
      w_p  = !reset && m_wvalid && !m_wready;
      ar_p = !reset && m_arvalid && !m_arready;
      aw_a = m_awaddr;
      w_v  = {m_wdata, m_wstrb};
      ar_a = m_araddr;
    end
  end

  task automatic send_write(input logic [8:0] id, input logic user, input logic [17:0] addr,
                            input logic [63:0] data, input logic [7:0] strb);
    int n = 0;
    s_awid = id; s_awuser = user; s_awaddr = addr; s_awsize = 3'd3;
    s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    while (!(s_awready && s_wready)) begin
      @(posedge clk); #1; n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL aw_accept_timeout: waited %0d cycles, required accept", n);
        break;
      end
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic wait_b(input int hold, output logic [1:0] resp, output logic [8:0] id,
                        output logic user);
    int n = 0;
    s_bready = 1'b0;
    while (!s_bvalid) begin
      @(posedge clk); #1; n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL b_timeout: waited %0d cycles, required bvalid", n);
        resp = 2'bxx; id = 9'hxxx; user = 1'bx;
        return;
      end
    end
    resp = s_bresp; id = s_bid; user = s_buser;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checks++;
      if (s_bvalid !== 1'b1 || s_bresp !== resp || s_bid !== id) begin
        errors++;
        $display("FAIL b_stable: valid=%b resp=%0d id=%h, required 1 %0d %h",
                 s_bvalid, s_bresp, s_bid, resp, id);
      end
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic send_read(input logic [8:0] id, input logic user, input logic [17:0] addr,
                           input logic [2:0] size);
    int n = 0;
    s_arid = id; s_aruser = user; s_araddr = addr; s_arsize = size;
    s_arvalid = 1'b1;
    #1;
    while (!s_arready) begin
      @(posedge clk); #1; n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL ar_accept_timeout: waited %0d cycles, required accept", n);
        break;
      end
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  // cyc counts from the AR accept cycle (cycle 0) to the cycle rvalid is seen.
  task automatic wait_r(input int hold, output logic [63:0] data, output logic [1:0] resp,
                        output logic [8:0] id, output logic user, output int cyc);
    cyc = 1;
    s_rready = 1'b0;
    while (!s_rvalid) begin
      @(posedge clk); #1; cyc++;
      if (cyc > 500) begin
        checks++; errors++;
        $display("FAIL r_timeout: waited %0d cycles, required rvalid", cyc);
        data = 64'hx; resp = 2'bxx; id = 9'hxxx; user = 1'bx;
        return;
      end
    end
    data = s_rdata; resp = s_rresp; id = s_rid; user = s_ruser;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== data || s_rresp !== resp) begin
        errors++;
        $display("FAIL r_stable: valid=%b data=%h resp=%0d, required 1 %h %0d",
                 s_rvalid, s_rdata, s_rresp, data, resp);
      end
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    reset = 1'b1;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
           m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready};
    checks++;
    if (obs !== 10'b0) begin
      errors++; $display("FAIL reset_outputs: got %b, required %b", obs, 10'b0);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_arready !== 1'b1) begin
      errors++; $display("FAIL idle_arready: got %b, required 1", s_arready);
    end
    s_awvalid = 1'b1; #1;
    checks++;
    if ({s_awready, s_wready} !== 2'b00) begin
      errors++; $display("FAIL aw_alone_ready: got %b, required 00", {s_awready, s_wready});
    end
    s_wvalid = 1'b1; #1;
    checks++;
    if ({s_awready, s_wready} !== 2'b11) begin
      errors++; $display("FAIL aw_w_ready: got %b, required 11", {s_awready, s_wready});
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write64();
    logic [1:0] resp; logic [8:0] id; logic user;
    wlog_addr.delete(); wlog_data.delete(); wlog_strb.delete();
    send_write(9'h1A5, 1'b1, 18'h40, 64'h1122334455667788, 8'hFF);
    wait_b(0, resp, id, user);
    checks++;
    if (wlog_addr.size() != 2) begin
      errors++; $display("FAIL w64_count: got %0d, required 2", wlog_addr.size());
    end else begin
      checks++;
      if ({wlog_addr[0], wlog_data[0], wlog_strb[0]} !== {18'h40, 32'h55667788, 4'hF}) begin
        errors++; $display("FAIL w64_lo: got %h %h %h, required 40 55667788 f",
                           wlog_addr[0], wlog_data[0], wlog_strb[0]);
      end
      checks++;
      if ({wlog_addr[1], wlog_data[1], wlog_strb[1]} !== {18'h44, 32'h11223344, 4'hF}) begin
        errors++; $display("FAIL w64_hi: got %h %h %h, required 44 11223344 f",
                           wlog_addr[1], wlog_data[1], wlog_strb[1]);
      end
    end
    checks++;
    if ({resp, id, user} !== {2'b00, 9'h1A5, 1'b1}) begin
      errors++; $display("FAIL w64_b: got resp=%0d id=%h user=%b, required 0 1a5 1",
                         resp, id, user);
    end
  endtask

  task automatic test_write_partial();
    logic [1:0] resp; logic [8:0] id; logic user;
    wlog_addr.delete(); wlog_data.delete(); wlog_strb.delete();
    send_write(9'h003, 1'b0, 18'h48, 64'hDEADBEEF_00000000, 8'hF0);
    wait_b(0, resp, id, user);
    checks++;
    if (wlog_addr.size() != 1) begin
      errors++; $display("FAIL whi_count: got %0d, required 1", wlog_addr.size());
    end else begin
      checks++;
      if ({wlog_addr[0], wlog_data[0], wlog_strb[0]} !== {18'h4C, 32'hDEADBEEF, 4'hF}) begin
        errors++; $display("FAIL whi_data: got %h %h %h, required 4c deadbeef f",
                           wlog_addr[0], wlog_data[0], wlog_strb[0]);
      end
    end
    checks++;
    if (resp !== 2'b00 || id !== 9'h003) begin
      errors++; $display("FAIL whi_b: got %0d %h, required 0 003", resp, id);
    end
    // Error merge: LO DECERR, HI SLVERR -> DECERR, and HI is still issued.
    wr_resp[32'h60] = 2'd3; wr_resp[32'h64] = 2'd2;
    wlog_addr.delete(); wlog_data.delete(); wlog_strb.delete();
    send_write(9'h0AA, 1'b0, 18'h60, 64'h0, 8'hFF);
    wait_b(0, resp, id, user);
    checks++;
    if (wlog_addr.size() != 2 || resp !== 2'd3) begin
      errors++; $display("FAIL werr_merge: got count=%0d resp=%0d, required 2 3",
                         wlog_addr.size(), resp);
    end
    wlog_addr.delete(); wlog_data.delete(); wlog_strb.delete();
    send_write(9'h004, 1'b1, 18'h58, 64'h1, 8'h00);
    wait_b(0, resp, id, user);
    checks++;
    if (wlog_addr.size() != 0) begin
      errors++; $display("FAIL wnull_count: got %0d, required 0", wlog_addr.size());
    end
    checks++;
    if ({resp, id, user} !== {2'b00, 9'h004, 1'b1}) begin
      errors++; $display("FAIL wnull_b: got %0d %h %b, required 0 004 1", resp, id, user);
    end
  endtask

  task automatic test_read64();
    logic [63:0] data; logic [1:0] resp; logic [8:0] id; logic user; int cyc;
    rd_mem[32'h10] = 32'hAAAA0000; rd_resp[32'h10] = 2'd0;
    rd_mem[32'h14] = 32'h0000BBBB; rd_resp[32'h14] = 2'd2;
    rlog.delete();
    send_read(9'h0F0, 1'b1, 18'h10, 3'd3);
    wait_r(0, data, resp, id, user, cyc);
    checks++;
    if (data !== 64'h0000BBBBAAAA0000) begin
      errors++; $display("FAIL r64_data: got %h, required 0000bbbbaaaa0000", data);
    end
    checks++;
    if ({resp, id, user} !== {2'd2, 9'h0F0, 1'b1}) begin
      errors++; $display("FAIL r64_resp: got %0d %h %b, required 2 0f0 1", resp, id, user);
    end
    checks++;
    if (rlog.size() != 2) begin
      errors++; $display("FAIL r64_count: got %0d, required 2", rlog.size());
    end else begin
      checks++;
      if ({rlog[0], rlog[1]} !== {18'h10, 18'h14}) begin
        errors++; $display("FAIL r64_addr: got %h %h, required 10 14", rlog[0], rlog[1]);
      end
    end
    checks++;
    if (cyc != 5) begin
      errors++; $display("FAIL r64_latency: got cycle %0d, required 5", cyc);
    end
  endtask

  task automatic test_read32();
    logic [63:0] data; logic [1:0] resp; logic [8:0] id; logic user; int cyc;
    rd_mem[32'h14] = 32'h12345678; rd_resp[32'h14] = 2'd0;
    rlog.delete();
    send_read(9'h011, 1'b0, 18'h14, 3'd2);
    wait_r(0, data, resp, id, user, cyc);
    checks++;
    if (data !== 64'h1234567812345678 || resp !== 2'd0 || id !== 9'h011) begin
      errors++; $display("FAIL r32_data: got %h %0d %h, required 1234567812345678 0 011",
                         data, resp, id);
    end
    checks++;
    if (rlog.size() != 1 || rlog[0] !== 18'h14) begin
      errors++; $display("FAIL r32_addr: got count=%0d, required one read at 14", rlog.size());
    end
    checks++;
    if (cyc != 3) begin
      errors++; $display("FAIL r32_latency: got cycle %0d, required 3", cyc);
    end
    rd_mem[32'h18] = 32'hCAFEF00D; rd_resp[32'h18] = 2'd3;
    rlog.delete();
    send_read(9'h012, 1'b1, 18'h1A, 3'd1);
    wait_r(0, data, resp, id, user, cyc);
    checks++;
    if (data !== 64'hCAFEF00DCAFEF00D || resp !== 2'd3) begin
      errors++; $display("FAIL r16_data: got %h %0d, required cafef00dcafef00d 3", data, resp);
    end
    checks++;
    if (rlog.size() != 1 || rlog[0] !== 18'h18) begin
      errors++; $display("FAIL r16_addr: got count=%0d, required one read at 18", rlog.size());
    end
  endtask

  task automatic test_back_to_back();
    int nbad;
    for (int i = 0; i < 6; i++) begin
      rd_mem[32'h300 + 8 * i] = 32'hC000_0000 + i;
      rd_mem[32'h304 + 8 * i] = 32'hD000_0000 + i;
    end
    wlog_addr.delete(); wlog_data.delete(); wlog_strb.delete();
    rlog.delete();
    stall_en = 1'b1;
    fork
      begin
        logic [1:0] resp; logic [8:0] id; logic user;
        for (int i = 0; i < 6; i++) begin
          send_write(9'(i + 9'h20), 1'(i), 18'h100 + 18'(8 * i),
                     {32'hA000_0000 + i, 32'hB000_0000 + i}, 8'hFF);
          wait_b(2, resp, id, user);
          checks++;
          if ({resp, id, user} !== {2'b00, 9'(i + 9'h20), 1'(i)}) begin
            errors++; $display("FAIL bp_b%0d: got %0d %h %b, required 0 %h %b",
                               i, resp, id, user, 9'(i + 9'h20), 1'(i));
          end
        end
      end
      begin
        logic [63:0] data; logic [1:0] resp; logic [8:0] id; logic user; int cyc;
        for (int i = 0; i < 6; i++) begin
          send_read(9'(i + 9'h40), 1'b0, 18'h300 + 18'(8 * i), 3'd3);
          wait_r(2, data, resp, id, user, cyc);
          checks++;
          if ({data, resp, id} !== {32'hD000_0000 + i, 32'hC000_0000 + i, 2'b00,
                                    9'(i + 9'h40)}) begin
            errors++; $display("FAIL bp_r%0d: got %h %0d %h", i, data, resp, id);
          end
        end
      end
    join
    stall_en = 1'b0;
    nbad = 0;
    for (int i = 0; i < wlog_addr.size(); i++) begin
      if (wlog_addr[i] !== 18'h100 + 18'(4 * i) || wlog_strb[i] !== 4'hF ||
          wlog_data[i] !== ((i % 2 == 0) ? 32'hB000_0000 + i / 2 : 32'hA000_0000 + i / 2))
        nbad++;
    end
    checks++;
    if (wlog_addr.size() != 12 || nbad != 0) begin
      errors++; $display("FAIL bp_wlog: got count=%0d bad=%0d, required 12 0",
                         wlog_addr.size(), nbad);
    end
    checks++;
    if (rlog.size() != 12) begin
      errors++; $display("FAIL bp_rlog: got count=%0d, required 12", rlog.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] resp; logic [8:0] id; logic user; int n;
    logic [6:0] obs;
    hold_b = 1'b1;
    send_write(9'h077, 1'b1, 18'h200, 64'h0123456789ABCDEF, 8'hFF);
    n = 0;
    while (!(m_bready && m_awaddr == 18'h204)) begin
      @(posedge clk); #1; n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL mid_hi_wait: waited %0d cycles, required HI awaiting B", n);
        break;
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    obs = {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready};
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got %b, required %b", obs, 7'b0);
    end
    reset = 1'b0; hold_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_bvalid, s_arready} !== 2'b01) begin
      errors++; $display("FAIL mid_idle: got bvalid,arready=%b, required 01",
                         {s_bvalid, s_arready});
    end
    wlog_addr.delete(); wlog_data.delete(); wlog_strb.delete();
    send_write(9'h078, 1'b0, 18'h208, 64'hFEEDFACE_0BADF00D, 8'hFF);
    wait_b(0, resp, id, user);
    checks++;
    if (wlog_addr.size() != 2 || {resp, id} !== {2'b00, 9'h078}) begin
      errors++; $display("FAIL mid_after: got count=%0d resp=%0d id=%h, required 2 0 078",
                         wlog_addr.size(), resp, id);
    end else begin
      checks++;
      if ({wlog_data[0], wlog_data[1], wlog_addr[1]} !==
          {32'h0BADF00D, 32'hFEEDFACE, 18'h20C}) begin
        errors++; $display("FAIL mid_after_data: got %h %h %h, required 0badf00d feedface 20c",
                           wlog_data[0], wlog_data[1], wlog_addr[1]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_bready = 1'b0; s_rready = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awsize = '0; s_awuser = 1'b0;
    s_wdata = '0; s_wstrb = '0;
    s_arid = '0; s_araddr = '0; s_arsize = '0; s_aruser = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_write64();
    test_write_partial();
    test_read64();
    test_read32();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
